// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte
// producers. One byte is accepted at a time and written to the transmitter.
// The arbiter then waits for tx_busy to rise. If tx_busy does not rise within
// START_TMO cycles, the byte is dropped and err_tmo pulses. Otherwise the
// arbiter waits for tx_busy to fall before it grants the next byte.
//
// Optional build macro: UART_ARB_PKT_LOCK_EN
//   When defined, a multi-byte packet (req_last low on every byte except the
//   final one) keeps the grant on the same requester until the packet ends.
//   When undefined, req_last is ignored.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   START_TMO  cycles allowed from tx_wr_en until tx_busy rises (>=2)
//
// Ports
//   clk_50m    in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]   byte pending per requester
//   req_data   in   [8*NUM_REQ] byte of requester i on [8*i+7:8*i]
//   req_last   in   [NUM_REQ]   final byte of packet (lock build only)
//   req_ack    out  [NUM_REQ]   one-cycle accept pulse
//   tx_din     out  [8]         byte to transmitter, held until next grant
//   tx_wr_en   out  1           one-cycle write strobe
//   tx_busy    in   1           transmitter busy
//   grant_id   out  [3]         last granted requester
//   arb_busy   out  1           arbiter not idle
//   err_tmo    out  1           one-cycle start-timeout pulse
// ---------------------------------------------------------------------------

module uart_tx_arbiter_chk #(
   parameter int NUM_REQ = 4
) (
   input logic               clk_50m,
   input logic               rst_n,
   input logic [NUM_REQ-1:0] req_ack,
   input logic               tx_wr_en,
   input logic               err_tmo
);

   // At most one requester is acknowledged in any cycle.
   a_ack_onehot0 : assert property (@(posedge clk_50m) disable iff (!rst_n)
      $onehot0(req_ack));

   // Each write strobe comes with exactly one acknowledge.
   a_wr_has_ack : assert property (@(posedge clk_50m) disable iff (!rst_n)
      tx_wr_en |-> $onehot(req_ack));

   // An acknowledge is never issued without a write strobe.
   a_ack_has_wr : assert property (@(posedge clk_50m) disable iff (!rst_n)
      (|req_ack) |-> tx_wr_en);

   // A timeout and a new write never occur in the same cycle.
   a_no_wr_on_err : assert property (@(posedge clk_50m) disable iff (!rst_n)
      err_tmo |-> !tx_wr_en);

endmodule

module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int START_TMO = 64
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [7:0]           tx_din,
   output logic                 tx_wr_en,
   input  logic                 tx_busy,
   output logic [2:0]           grant_id,
   output logic                 arb_busy,
   output logic                 err_tmo
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_START = 2'd1,
      ST_WAIT_DONE  = 2'd2
   } state_t;

   localparam int CNT_W = (START_TMO > 2) ? $clog2(START_TMO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TMO - 1);

   // (base + off) mod NUM_REQ. Both operands are below NUM_REQ, so one
   // conditional subtract is enough.
   function automatic logic [2:0] wrap_inc(input logic [2:0] base, input logic [3:0] off);
      logic [4:0] sum;
      sum = {2'b00, base} + {1'b0, off};
      return (sum >= 5'(NUM_REQ)) ? 3'(sum - 5'(NUM_REQ)) : 3'(sum);
   endfunction

   state_t               state_q, state_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           tx_din_q, tx_din_d;
   logic                 tx_wr_en_q, tx_wr_en_d;
   logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
   logic [2:0]           grant_id_q, grant_id_d;
   logic                 arb_busy_q, arb_busy_d;
   logic                 err_tmo_q, err_tmo_d;

   // Inputs are padded to the 8-requester maximum. This lets the 3-bit
   // requester indices address them directly for any NUM_REQ.
   logic [7:0]           valid_pad_s;
   logic [63:0]          data_pad_s;
   logic [2:0]           rr_win_s;
   logic                 rr_found_s;
   logic [2:0]           win_s;
   logic                 win_ok_s;

   assign valid_pad_s = 8'(req_valid);
   assign data_pad_s  = 64'(req_data);

   // Round-robin search. The first valid requester at or after ptr wins.
   always_comb begin
      rr_found_s = 1'b0;
      rr_win_s   = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!rr_found_s && valid_pad_s[wrap_inc(ptr_q, 4'(k))]) begin
            rr_found_s = 1'b1;
            rr_win_s   = wrap_inc(ptr_q, 4'(k));
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

`ifdef UART_ARB_PKT_LOCK_EN
   logic                 lock_q, lock_d;
   logic [2:0]           lock_id_q, lock_id_d;
   logic [7:0]           last_pad_s;

   assign last_pad_s = 8'(req_last);

   // While a packet is in progress, only its owner can win. The arbiter
   // keeps waiting for the owner even if it drops req_valid.
   always_comb begin
      if (lock_q) begin
         win_s    = lock_id_q;
         win_ok_s = valid_pad_s[lock_id_q];
      end else begin
         win_s    = rr_win_s;
         win_ok_s = rr_found_s;
      end
   end
`else
   logic unused_last_s;

   assign unused_last_s = ^req_last;
   assign win_s         = rr_win_s;
   assign win_ok_s      = rr_found_s;
`endif

   // Next-state and next-output logic for the grant / start / done sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      tx_din_d   = tx_din_q;
      grant_id_d = grant_id_q;
      tx_wr_en_d = 1'b0;
      req_ack_d  = '0;
      err_tmo_d  = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_d     = lock_q;
      lock_id_d  = lock_id_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // A busy transmitter blocks every grant. This also covers a frame
            // that is still in flight after a reset.
            if (!tx_busy && win_ok_s) begin
               tx_din_d   = data_pad_s[{win_s, 3'b000} +: 8];
               grant_id_d = win_s;
               tx_wr_en_d = 1'b1;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_ack_d[i] = (3'(i) == win_s);
               end
               cnt_d      = '0;
               state_d    = ST_WAIT_START;
`ifdef UART_ARB_PKT_LOCK_EN
               if (last_pad_s[win_s]) begin
                  lock_d = 1'b0;
                  ptr_d  = wrap_inc(win_s, 4'd1);
               end else begin
                  lock_d    = 1'b1;
                  lock_id_d = win_s;
               end
`else
               ptr_d      = wrap_inc(win_s, 4'd1);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_START: begin
            // tx_busy is checked before the limit. A rise on the last
            // allowed cycle therefore still counts as a start.
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_tmo_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
               if (lock_q) begin
                  lock_d = 1'b0;
                  ptr_d  = wrap_inc(lock_id_q, 4'd1);
               end else begin
                  lock_d = 1'b0;
               end
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      arb_busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 3'd0;
         cnt_q      <= '0;
         tx_din_q   <= 8'h00;
         tx_wr_en_q <= 1'b0;
         req_ack_q  <= '0;
         grant_id_q <= 3'd0;
         arb_busy_q <= 1'b0;
         err_tmo_q  <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q     <= 1'b0;
         lock_id_q  <= 3'd0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         tx_din_q   <= tx_din_d;
         tx_wr_en_q <= tx_wr_en_d;
         req_ack_q  <= req_ack_d;
         grant_id_q <= grant_id_d;
         arb_busy_q <= arb_busy_d;
         err_tmo_q  <= err_tmo_d;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q     <= lock_d;
         lock_id_q  <= lock_id_d;
`endif
      end
   end

   assign req_ack  = req_ack_q;
   assign tx_din   = tx_din_q;
   assign tx_wr_en = tx_wr_en_q;
   assign grant_id = grant_id_q;
   assign arb_busy = arb_busy_q;
   assign err_tmo  = err_tmo_q;

   uart_tx_arbiter_chk #(
      .NUM_REQ (NUM_REQ)
   ) u_chk (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .req_ack  (req_ack_q),
      .tx_wr_en (tx_wr_en_q),
      .err_tmo  (err_tmo_q)
   );

endmodule
